mccoy_prog_feeder: RTL and testbench

Program-store and sequencing stage directly upstream of the McCoy core. It accepts a program over a valid/ready load port into a small register-array store. It then supplies the core's 6-bit `instr` each cycle by indexing the store with the core's current `pc`, holding the core in reset whenever it is not running. It halts the run when `pc` leaves the loaded program and counts executed cycles.

---
 rtl/mccoy_feeder_pkg.sv | 22 ++
 rtl/feeder_mem.sv | 27 ++
 rtl/mccoy_prog_feeder.sv | 168 ++++++++++++++++
 tb/tb_mccoy_prog_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccoy_feeder_pkg.sv
// Shared encodings and widths for the McCoy program feeder.
package mccoy_feeder_pkg;

  localparam int unsigned INSTR_W = 6;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned CYC_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 6'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Saturating increment for the RUN cycle counter.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + CYC_W'(1);
  endfunction

endpackage

// File: rtl/feeder_mem.sv
// DEPTH x INSTR_W program store: synchronous write, asynchronous read.
module feeder_mem
  import mccoy_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  // Not reset: contents survive a reset and are gated by prog_len instead.
  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mccoy_prog_feeder.sv
// Program store loader and run sequencer in front of the McCoy core.
// Optional breakpoint support is enabled by defining MCCOY_FEEDER_BKPT_EN.
module mccoy_prog_feeder
  import mccoy_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [INSTR_W-1:0]       load_data,
  output logic                     load_ready,
  input  logic                     load_done,
  input  logic                     run_start,
  input  logic [PC_W-1:0]          pc,
  output logic [INSTR_W-1:0]       instr,
  output logic                     core_reset,
  output logic [1:0]               state,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic [CYC_W-1:0]         run_cycles
`ifdef MCCOY_FEEDER_BKPT_EN
  ,
  input  logic                     bkpt_en,
  input  logic [PC_W-1:0]          bkpt_addr,
  output logic                     bkpt_hit
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CMP_W = (PC_W > LW) ? PC_W : LW;
  localparam logic [AW:0] DEPTH_CNT = LW'(DEPTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_prog_len;
  logic [CYC_W-1:0]   r_run_cycles;
  logic [INSTR_W-1:0] w_rdata;
  logic [INSTR_W-1:0] w_instr;
  logic               w_core_reset;
  logic               w_load_ready;
  logic               w_wr_en;
  logic               w_ptr_clr;
  logic               w_cyc_clr;
  logic               w_cyc_inc;
  logic               w_oor;
  logic               w_bkpt;

  feeder_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (load_data),
    .i_raddr (pc[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Full-width compare so a wrapped or high pc never aliases into the store.
  assign w_oor = CMP_W'(pc) >= CMP_W'(r_prog_len);

`ifdef MCCOY_FEEDER_BKPT_EN
  assign w_bkpt = bkpt_en && (pc == bkpt_addr);
`else
  assign w_bkpt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_wr_en      = 1'b0;
    w_ptr_clr    = 1'b0;
    w_cyc_clr    = 1'b0;
    w_cyc_inc    = 1'b0;
    w_instr      = NOP_INSTR;
    w_core_reset = 1'b1;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (load_start) begin
          w_next_state = ST_LOAD;
          w_ptr_clr    = 1'b1;
        end else if (run_start && (r_prog_len != '0)) begin
          w_next_state = ST_RUN;
          w_cyc_clr    = 1'b1;
        end
      end
      ST_LOAD: begin
        w_load_ready = (r_wr_ptr < DEPTH_CNT);
        w_wr_en      = load_valid && w_load_ready;
        if (load_done) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_core_reset = 1'b0;
        w_cyc_inc    = 1'b1;
        if (w_oor || w_bkpt) begin
          w_next_state = ST_HALT;
        end else begin
          w_instr = w_rdata;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Write pointer, program length and cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_prog_len   <= '0;
      r_run_cycles <= '0;
    end else begin
      if (w_ptr_clr) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + LW'(1);
        r_prog_len <= r_wr_ptr + LW'(1);
      end
      if (w_cyc_clr) begin
        r_run_cycles <= '0;
      end else if (w_cyc_inc) begin
        r_run_cycles <= sat_inc(r_run_cycles);
      end
    end
  end

`ifdef MCCOY_FEEDER_BKPT_EN
  logic r_bkpt_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bkpt_hit <= 1'b0;
    end else if ((r_state == ST_RUN) && w_bkpt) begin
      r_bkpt_hit <= 1'b1;
    end else if ((r_state == ST_HALT) && (w_next_state != ST_HALT)) begin
      r_bkpt_hit <= 1'b0;
    end
  end

  assign bkpt_hit = r_bkpt_hit;
`endif

  assign load_ready = w_load_ready;
  assign instr      = w_instr;
  assign core_reset = w_core_reset;
  assign state      = r_state;
  assign halted     = (r_state == ST_HALT);
  assign prog_len   = r_prog_len;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_mccoy_prog_feeder.sv
// Scoreboard bench for mccoy_prog_feeder; breakpoint cases need MCCOY_FEEDER_BKPT_EN.
module tb_mccoy_prog_feeder;
  import mccoy_feeder_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               load_done;
  logic               run_start;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               core_reset;
  logic [1:0]         state;
  logic               halted;
  logic [AW:0]        prog_len;
  logic [CYC_W-1:0]   run_cycles;
`ifdef MCCOY_FEEDER_BKPT_EN
  logic               bkpt_en;
  logic [PC_W-1:0]    bkpt_addr;
  logic               bkpt_hit;
`endif

  mccoy_prog_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .run_start  (run_start),
    .pc         (pc),
    .instr      (instr),
    .core_reset (core_reset),
    .state      (state),
    .halted     (halted),
    .prog_len   (prog_len),
    .run_cycles (run_cycles)
`ifdef MCCOY_FEEDER_BKPT_EN
    ,
    .bkpt_en    (bkpt_en),
    .bkpt_addr  (bkpt_addr),
    .bkpt_hit   (bkpt_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {S_STATE, S_INSTR, S_CRST, S_READY, S_HALTED, S_LEN,
                    S_CYC, S_BKPT, S_MEM2, S_WRQ} sel_t;
  typedef struct {
    string name;
    sel_t  sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   wr_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int actual(input sel_t s);
    case (s)
      S_STATE:  return int'(state);
      S_INSTR:  return int'(instr);
      S_CRST:   return int'(core_reset);
      S_READY:  return int'(load_ready);
      S_HALTED: return int'(halted);
      S_LEN:    return int'(prog_len);
      S_CYC:    return int'(run_cycles);
`ifdef MCCOY_FEEDER_BKPT_EN
      S_BKPT:   return int'(bkpt_hit);
`endif
      S_MEM2:   return int'(dut.u_mem.r_mem[2]);
      S_WRQ:    return wr_q.size();
      default:  return -1;
    endcase
  endfunction

  // Monitor: scores every accepted load word and every queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    int   idx;
    if (load_valid && load_ready) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: got handshake at prog_len=%0d, expected none", prog_len);
      end else begin
        idx = wr_q.pop_front();
        if (int'(prog_len) != idx) begin
          errors++;
          $display("FAIL wr_index: got %0d expected %0d", prog_len, idx);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a != e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input sel_t s, input int v);
    exp_q.push_back('{name: n, sel: s, val: v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [INSTR_W-1:0] words [4];
    words = '{6'h11, 6'h22, 6'h33, 6'h04};
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_done = 1'b0; run_start = 1'b0; pc = '0;
`ifdef MCCOY_FEEDER_BKPT_EN
    bkpt_en = 1'b0; bkpt_addr = '0;
`endif
    tick(); tick();
    expect_v("rst_state", S_STATE, 0);
    expect_v("rst_len", S_LEN, 0);
    expect_v("rst_cyc", S_CYC, 0);
    expect_v("rst_instr", S_INSTR, 0);
    expect_v("rst_crst", S_CRST, 1);
    expect_v("rst_ready", S_READY, 0);
    expect_v("rst_halted", S_HALTED, 0);
    reset = 1'b0;
    tick();

    // run_start with empty store is ignored; load_start wins a tie
    run_start = 1'b1; tick(); run_start = 1'b0;
    expect_v("guard_idle", S_STATE, 0);
    expect_v("guard_crst", S_CRST, 1);
    load_start = 1'b1; run_start = 1'b1; tick(); load_start = 1'b0; run_start = 1'b0;
    expect_v("tie_load", S_STATE, 1);
    expect_v("tie_ready", S_READY, 1);
    expect_v("tie_len", S_LEN, 0);

    // four words, last one alongside load_done
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_done = (i == 3);
      wr_q.push_back(i);
      tick();
    end
    load_valid = 1'b0; load_done = 1'b0;
    expect_v("load_idle", S_STATE, 0);
    expect_v("load_len", S_LEN, 4);
    expect_v("load_ready_off", S_READY, 0);

    // run through pc 0..4, halt one edge after pc=4
    run_start = 1'b1; tick(); run_start = 1'b0;
    expect_v("run_state", S_STATE, 2);
    expect_v("run_crst", S_CRST, 0);
    expect_v("run_halted", S_HALTED, 0);
    for (int p = 0; p < 5; p++) begin
      pc = PC_W'(p);
      expect_v("run_instr", S_INSTR, (p < 4) ? int'(words[p]) : 0);
      expect_v("run_cyc", S_CYC, p);
      expect_v("run_still", S_STATE, 2);
      tick();
    end
    expect_v("halt_state", S_STATE, 3);
    expect_v("halt_cyc", S_CYC, 5);
    expect_v("halt_crst", S_CRST, 1);
    expect_v("halt_halted", S_HALTED, 1);
    expect_v("halt_instr", S_INSTR, 0);
    tick();
    expect_v("halt_cyc_hold", S_CYC, 5);

    // high pc bits must not alias onto a stored word
    pc = 8'h42;
    run_start = 1'b1; tick(); run_start = 1'b0;
    expect_v("alias_state", S_STATE, 2);
    expect_v("alias_cyc0", S_CYC, 0);
    expect_v("alias_instr", S_INSTR, 0);
    tick();
    expect_v("alias_halt", S_STATE, 3);
    expect_v("alias_cyc1", S_CYC, 1);

    // reset at run_cycles=7
    pc = 8'd1;
    run_start = 1'b1; tick(); run_start = 1'b0;
    repeat (7) tick();
    expect_v("mid_cyc", S_CYC, 7);
    expect_v("mid_instr", S_INSTR, 'h22);
    reset = 1'b1; tick(); reset = 1'b0;
    expect_v("rr_state", S_STATE, 0);
    expect_v("rr_cyc", S_CYC, 0);
    expect_v("rr_len", S_LEN, 0);
    expect_v("rr_crst", S_CRST, 1);

    // zero-word load keeps store contents but cannot run
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_done = 1'b1; tick(); load_done = 1'b0;
    expect_v("zl_state", S_STATE, 0);
    expect_v("zl_len", S_LEN, 0);
    expect_v("zl_mem2", S_MEM2, 'h33);
    run_start = 1'b1; tick(); run_start = 1'b0;
    expect_v("zl_guard", S_STATE, 0);

    // backpressure: DEPTH+3 valids, only DEPTH accepted
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      load_data = INSTR_W'(i ^ 'h2A);
      if (i < DEPTH) begin
        wr_q.push_back(i);
        expect_v("bp_ready_on", S_READY, 1);
      end else begin
        expect_v("bp_ready_off", S_READY, 0);
      end
      tick();
    end
    load_valid = 1'b0;
    expect_v("bp_len", S_LEN, DEPTH);
    expect_v("bp_state", S_STATE, 1);
    load_done = 1'b1; tick(); load_done = 1'b0;
    expect_v("bp_idle", S_STATE, 0);

    run_start = 1'b1; tick(); run_start = 1'b0;
    pc = 8'd5;
    expect_v("bp_instr5", S_INSTR, int'(INSTR_W'(5 ^ 'h2A)));
    tick();
    pc = PC_W'(DEPTH - 1);
    expect_v("bp_instr_last", S_INSTR, int'(INSTR_W'((DEPTH - 1) ^ 'h2A)));
    tick();
    pc = PC_W'(DEPTH);
    expect_v("bp_instr_oor", S_INSTR, 0);
    tick();
    expect_v("bp_halt", S_STATE, 3);
    expect_v("bp_halt_cyc", S_CYC, 3);

`ifdef MCCOY_FEEDER_BKPT_EN
    run_start = 1'b1; tick(); run_start = 1'b0;
    pc = 8'd0; tick();
    pc = 8'd1; tick();
    pc = 8'd2; bkpt_en = 1'b1; bkpt_addr = 8'd2;
    expect_v("bk_instr", S_INSTR, 0);
    expect_v("bk_pre", S_BKPT, 0);
    tick();
    expect_v("bk_halt", S_STATE, 3);
    expect_v("bk_hit", S_BKPT, 1);
    expect_v("bk_cyc", S_CYC, 3);
    bkpt_en = 1'b0;
    run_start = 1'b1; tick(); run_start = 1'b0;
    expect_v("bk_restart", S_STATE, 2);
    expect_v("bk_clear", S_BKPT, 0);
    expect_v("bk_cyc0", S_CYC, 0);
    pc = PC_W'(DEPTH); tick();
`endif

    expect_v("wr_leftover", S_WRQ, 0);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
